// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path.
// The incoming serial line is synchronised to sysclk. The receiver qualifies the start bit
// at mid-bit, then takes one sample of each data bit (LSB first) at its centre and checks
// the stop bit. Each good byte is delivered with a one-cycle RX_STATUS strobe.
// A bad stop bit gives a one-cycle RX_FERR strobe, and the receiver then waits for the line
// to return to idle.
module uart_receiver #(
  parameter int BAUD_DIV = 5208,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_FERR,
  output logic       recvstatus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam logic [13:0] HALF_LAST = 14'(HALF_DIV - 1);
  localparam logic [13:0] BAUD_LAST = 14'(BAUD_DIV - 1);

  logic       rx_meta_reg;
  logic       rx_s_reg;
  state_t     state_reg,     state_next;
  logic [13:0] cnt_reg,      cnt_next;
  logic [2:0] bit_idx_reg,   bit_idx_next;
  logic [7:0] shreg_reg,     shreg_next;
  logic [7:0] rx_data_reg,   rx_data_next;
  logic       rx_status_reg, rx_status_next;
  logic       rx_ferr_reg,   rx_ferr_next;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= UART_RX;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // State, bit timing counter, shift register and output registers.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shreg_reg     <= '0;
      rx_data_reg   <= '0;
      rx_status_reg <= 1'b0;
      rx_ferr_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shreg_reg     <= shreg_next;
      rx_data_reg   <= rx_data_next;
      rx_status_reg <= rx_status_next;
      rx_ferr_reg   <= rx_ferr_next;
    end
  end

  // Next-state logic: decisions are taken at bit centres; strobes default low so they last one cycle.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shreg_next     = shreg_reg;
    rx_data_next   = rx_data_reg;
    rx_status_next = 1'b0;
    rx_ferr_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          // A line that is high again at mid-start-bit was only a glitch.
          state_next   = rx_s_reg ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 14'd1;
        end
      end
      DATA: begin
        if (cnt_reg == BAUD_LAST) begin
          cnt_next     = '0;
          shreg_next   = {rx_s_reg, shreg_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + 14'd1;
        end
      end
      STOP: begin
        if (cnt_reg == BAUD_LAST) begin
          cnt_next = '0;
          // Return to IDLE at stop-bit centre so a start bit that follows directly is caught.
          if (rx_s_reg) begin
            rx_data_next   = shreg_reg;
            rx_status_next = 1'b1;
            state_next     = IDLE;
          end else begin
            rx_ferr_next = 1'b1;
            state_next   = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 14'd1;
        end
      end
      BREAK: begin
        // A line held low must not be read again as a stream of 0x00 frames.
        if (rx_s_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign RX_DATA    = rx_data_reg;
  assign RX_STATUS  = rx_status_reg;
  assign RX_FERR    = rx_ferr_reg;
  assign recvstatus = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives 8N1 frames at exactly BAUD_DIV cycles per bit.
// A frame-level model (a queue of expected byte/stop outcomes with their start times) is
// checked every cycle against the strobes and RX_DATA. Literal checkpoints pin the model.
module tb_uart_receiver;

  localparam int B = 16;
  localparam int H = B / 2;
  localparam int LAT = 3 + H + 9 * B;  // cycle count from the driving edge to the visible strobe

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       UART_RX = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       RX_FERR;
  logic       recvstatus;

  uart_receiver #(.BAUD_DIV(B)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .RX_DATA   (RX_DATA),
    .RX_STATUS (RX_STATUS),
    .RX_FERR   (RX_FERR),
    .recvstatus(recvstatus)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int status_cnt = 0;
  int ferr_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       ok;
    int         start;
  } exp_t;
  exp_t exp_q[$];
  logic [7:0] model_data = 8'h00;
  logic       prev_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every strobe must match the next expected frame outcome in kind and timing.
  always @(negedge sysclk) begin
    if (!reset) begin
      model_data = 8'h00;
      prev_pulse = 1'b0;
    end else begin
      if (RX_STATUS || RX_FERR) begin
        chk("strobes_exclusive", {30'd0, RX_STATUS, RX_FERR} == 32'd3, 32'd0);
        chk("no_back_to_back_strobe", {31'd0, prev_pulse}, 32'd0);
        if (RX_STATUS) status_cnt++;
        if (RX_FERR) ferr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {31'd0, RX_STATUS, 1'b0} | {31'd0, RX_FERR}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_kind_status", {31'd0, RX_STATUS}, {31'd0, e.ok});
          checks++;
          if (cyc < e.start + LAT - 1 || cyc > e.start + LAT + 1) begin
            errors++;
            $display("FAIL strobe_latency: strobe at cycle %0d, expected %0d..%0d",
                     cyc, e.start + LAT - 1, e.start + LAT + 1);
          end
          if (e.ok) model_data = e.data;
        end
      end
      chk("rx_data_vs_model", {24'd0, RX_DATA}, {24'd0, model_data});
      prev_pulse = RX_STATUS | RX_FERR;
    end
  end

  // Advance n clock edges and settle just after the last one.
  task automatic hold(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    exp_t e;
    e.data = d;
    e.ok = stop_bit;
    e.start = cyc;
    exp_q.push_back(e);
    UART_RX = 1'b0;
    hold(B);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      hold(B);
    end
    UART_RX = stop_bit;
    hold(B);
  endtask

  logic [7:0] b2b [3] = '{8'h00, 8'hFF, 8'h80};

  initial begin
    int s;
    logic saw_busy;
    logic [7:0] partial;

    // Reset state
    reset = 1'b0;
    hold(3);
    chk("reset_rx_data", {24'd0, RX_DATA}, 32'h00);
    chk("reset_rx_status", {31'd0, RX_STATUS}, 32'd0);
    chk("reset_rx_ferr", {31'd0, RX_FERR}, 32'd0);
    chk("reset_recvstatus", {31'd0, recvstatus}, 32'd0);
    reset = 1'b1;
    hold(5);

    // Two good frames
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    hold(4);
    chk("t1_rx_data_a3", {24'd0, RX_DATA}, 32'hA3);
    chk("t1_status_count", status_cnt, 32'd2);
    chk("t1_ferr_count", ferr_cnt, 32'd0);

    // Short low glitch on an idle line
    s = cyc;
    saw_busy = 1'b0;
    UART_RX = 1'b0;
    hold(3);
    UART_RX = 1'b1;
    if (recvstatus) saw_busy = 1'b1;
    for (int k = 0; k < H; k++) begin
      hold(1);
      if (recvstatus && cyc < s + H + 3) saw_busy = 1'b1;
    end
    chk("t2_glitch_seen_busy", {31'd0, saw_busy}, 32'd1);
    chk("t2_elapsed", cyc - s, H + 3);
    chk("t2_recvstatus_dropped", {31'd0, recvstatus}, 32'd0);
    hold(2 * B);
    chk("t2_status_count", status_cnt, 32'd2);

    // Framing error followed by a held-low line
    send_frame(8'hA5, 1'b0);
    hold(40);
    chk("t3_in_break", {31'd0, recvstatus}, 32'd1);
    chk("t3_ferr_count", ferr_cnt, 32'd1);
    chk("t3_rx_data_kept", {24'd0, RX_DATA}, 32'hA3);
    UART_RX = 1'b1;
    hold(4);
    chk("t3_break_exit", {31'd0, recvstatus}, 32'd0);
    hold(2 * B);
    chk("t3_no_zero_frame", status_cnt, 32'd2);

    // Back-to-back frames
    for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b1);
    hold(4);
    chk("t4_status_count", status_cnt, 32'd5);
    chk("t4_rx_data_80", {24'd0, RX_DATA}, 32'h80);

    // Reset in the middle of data bit 4 of 0x3C
    partial = 8'h3C;
    UART_RX = 1'b0;
    hold(B);
    for (int i = 0; i < 4; i++) begin
      UART_RX = partial[i];
      hold(B);
    end
    UART_RX = partial[4];
    hold(H);
    reset = 1'b0;
    UART_RX = 1'b1;
    #1;
    chk("t5_reset_rx_data", {24'd0, RX_DATA}, 32'h00);
    chk("t5_reset_recvstatus", {31'd0, recvstatus}, 32'd0);
    hold(3);
    reset = 1'b1;
    hold(2 * B);
    chk("t5_no_strobe_aborted", status_cnt, 32'd5);
    chk("t5_rx_data_zero", {24'd0, RX_DATA}, 32'h00);
    send_frame(8'h81, 1'b1);
    hold(4);
    chk("t5_rx_data_81", {24'd0, RX_DATA}, 32'h81);

    // Every byte value, back to back
    for (int v = 0; v < 256; v++) send_frame(v[7:0], 1'b1);
    hold(20);
    chk("t6_status_count", status_cnt, 32'd262);
    chk("t6_ferr_count", ferr_cnt, 32'd1);
    chk("t6_rx_data_ff", {24'd0, RX_DATA}, 32'hFF);
    chk("all_frames_accounted", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
